vend_ctrl: RTL and testbench
============================

// Module: vend_ctrl
// PURPOSE
//   Vending-machine control FSM sitting directly upstream of the sum register.
//   Accepts coin pulses and computes the next running total. Drives the register's
//   load, next-value and active-low clear inputs, and reads its o_sum back on i_sum.
//   When the total reaches PRICE it requests a vend with change; on cancel it
//   requests a refund. Both requests use a valid/ack handshake with the dispenser.
// PARAMETERS
//   SUM_W      3   width of running total (matches sum register)
//   PRICE      4   item price in nickel units (1..2**SUM_W-1)
//   NICKEL_V   1   value of nickel in units
//   DIME_V     2   value of dime in units
//   QUARTER_V  5   value of quarter in units; PRICE-1+QUARTER_V-PRICE < 2**SUM_W
// PORTS
//   i_clk        in   1      clock, all state on rising edge
//   i_rst        in   1      asynchronous active-low reset
//   i_nickel     in   1      nickel inserted, 1-cycle pulse, pre-synchronised
//   i_dime       in   1      dime inserted, 1-cycle pulse
//   i_quarter    in   1      quarter inserted, 1-cycle pulse
//   i_cancel     in   1      cancel request, 1-cycle pulse
//   i_sum        in   SUM_W  current total from sum register
//   i_vend_ack   in   1      dispenser accepted vend/refund request
//   o_sum_ld     out  1      load strobe to sum register
//   o_sum_next   out  SUM_W  next total to sum register
//   o_sum_rst    out  1      active-low clear to sum register
//   o_vend       out  1      vend request (level, held until ack)
//   o_refund     out  1      refund request (level, held until ack)
//   o_change     out  SUM_W  change/refund amount, valid while o_vend|o_refund
//   o_coin_rej   out  1      1-cycle pulse: coin rejected (returned to user)
//   o_busy       out  1      high in VEND or REFUND
// BEHAVIOUR
//   States: COLLECT, VEND, REFUND. Reset -> COLLECT.
//   Reset values: o_vend=0, o_refund=0, o_change=0, o_coin_rej=0, o_busy=0.
//   o_sum_rst=0 while i_rst low, so the register clears on clocks during reset.
//   Sum-register strobes (o_sum_ld, o_sum_next, o_sum_rst) are combinational from state and inputs.
//     The register and FSM update on the same edge.
//   Defaults: o_sum_ld=0, o_sum_rst=1, o_sum_next=i_sum.
//   Coin valid = exactly one of nickel/dime/quarter high, in COLLECT, without i_cancel.
//   Otherwise any coin pulse is rejected: sum unchanged, o_coin_rej=1 next cycle.
//   COLLECT, valid coin: total = i_sum + value, computed SUM_W+1 bits wide.
//     total < PRICE  -> o_sum_ld=1, o_sum_next=total[SUM_W-1:0], stay.
//     total >= PRICE -> o_sum_rst=0; change_reg <= total-PRICE; go to VEND.
//   COLLECT, i_cancel and i_sum!=0 -> change_reg<=i_sum, o_sum_rst=0, go to REFUND.
//     i_cancel with i_sum==0 is ignored. Cancel wins over a same-cycle coin, which is rejected.
//   VEND: o_vend=1, o_change=change_reg. On i_vend_ack -> COLLECT.
//     o_vend and o_change drop on the following cycle. No timeout.
//   REFUND: o_refund=1, o_change=change_reg. On i_vend_ack -> COLLECT.
//   i_cancel is ignored in VEND and REFUND. Coins there are rejected.
//   i_vend_ack outside VEND/REFUND is ignored.
//   o_vend, o_refund, o_change and o_coin_rej are registered. o_busy = state!=COLLECT.
//   Asynchronous reset mid-VEND/REFUND: outputs drop immediately; pending change is lost.
// TESTING
//   4 nickels: o_sum_next 1,2,3 with ld; 4th gives o_sum_rst=0, then o_vend=1, o_change=0.
//     Ack -> o_vend=0 next cycle.
//   Sum=3, quarter: total 8 with no overflow; o_vend=1, o_change=4; sum register clears to 0.
//   Sum=2, nickel+dime same cycle: no ld; o_coin_rej=1 one cycle later; sum stays 2.
//   Sum=3, cancel: o_refund=1, o_change=3, sum clears. Cancel at sum=0: no state change.
//   In VEND with ack low 10 cycles, dime pulse: o_vend held, o_coin_rej pulses, sum stays 0.
//   i_rst low mid-VEND: o_vend=0, o_change=0 without clock. After release, COLLECT accepts a nickel: sum=1.

Source files
------------

// File: rtl/vend_ctrl_if.sv
// Vending controller bus bundle.
//   Coin/cancel pulses from the coin mech, the sum-register strobes and
//   read-back, and the vend/refund valid/ack handshake with the dispenser.
//   master : the controller (vend_ctrl)
//   slave  : the surrounding environment (coin mech, sum register, dispenser)
interface vend_ctrl_if #(
  parameter int SUM_W = 3
);
  logic             i_nickel;
  logic             i_dime;
  logic             i_quarter;
  logic             i_cancel;
  logic [SUM_W-1:0] i_sum;
  logic             i_vend_ack;
  logic             o_sum_ld;
  logic [SUM_W-1:0] o_sum_next;
  logic             o_sum_rst;
  logic             o_vend;
  logic             o_refund;
  logic [SUM_W-1:0] o_change;
  logic             o_coin_rej;
  logic             o_busy;

  modport master (
    input  i_nickel, i_dime, i_quarter, i_cancel, i_sum, i_vend_ack,
    output o_sum_ld, o_sum_next, o_sum_rst,
    output o_vend, o_refund, o_change, o_coin_rej, o_busy
  );

  modport slave (
    output i_nickel, i_dime, i_quarter, i_cancel, i_sum, i_vend_ack,
    input  o_sum_ld, o_sum_next, o_sum_rst,
    input  o_vend, o_refund, o_change, o_coin_rej, o_busy
  );
endinterface

// File: rtl/vend_ctrl.sv
// Vending-machine control FSM, directly upstream of the sum register.
//   i_clk : clock, all state on rising edge
//   i_rst : asynchronous active-low reset
//   bus   : vend_ctrl_if.master
//     in : i_nickel/i_dime/i_quarter/i_cancel (1-cycle pulses), i_sum (register
//          read-back), i_vend_ack (dispenser accept)
//     out: o_sum_ld/o_sum_next/o_sum_rst (combinational register strobes),
//          o_vend/o_refund/o_change/o_coin_rej (registered), o_busy
// Coins accumulate in the external sum register. Reaching PRICE clears the
// register and raises a vend request carrying the change; cancel clears it and
// raises a refund request. Both requests hold until i_vend_ack.
module vend_ctrl #(
  parameter int SUM_W     = 3,
  parameter int PRICE     = 4,
  parameter int NICKEL_V  = 1,
  parameter int DIME_V    = 2,
  parameter int QUARTER_V = 5
) (
  input logic        i_clk,
  input logic        i_rst,
  vend_ctrl_if.master bus
);

  localparam logic [SUM_W:0] NICKEL_C  = (SUM_W+1)'(NICKEL_V);
  localparam logic [SUM_W:0] DIME_C    = (SUM_W+1)'(DIME_V);
  localparam logic [SUM_W:0] QUARTER_C = (SUM_W+1)'(QUARTER_V);
  localparam logic [SUM_W:0] PRICE_C   = (SUM_W+1)'(PRICE);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VEND    = 2'd1,
    REFUND  = 2'd2
  } state_t;

  state_t           state_q,    state_d;
  logic [SUM_W-1:0] change_q,   change_d;
  logic             vend_q,     vend_d;
  logic             refund_q,   refund_d;
  logic             coin_rej_q, coin_rej_d;

  logic             sum_ld;
  logic [SUM_W-1:0] sum_next;
  logic             sum_rst;

  logic             coin_any;
  logic             coin_ok;
  logic [SUM_W:0]   coin_val;
  logic [SUM_W:0]   total;
  logic [SUM_W:0]   over;

  always_comb begin
    coin_any = bus.i_nickel | bus.i_dime | bus.i_quarter;
    // Cancel (even an ignored one at sum 0) disqualifies a same-cycle coin.
    coin_ok  = (state_q == COLLECT) && !bus.i_cancel &&
               $onehot({bus.i_nickel, bus.i_dime, bus.i_quarter});

    coin_val = '0;
    if (bus.i_nickel)       coin_val = NICKEL_C;
    else if (bus.i_dime)    coin_val = DIME_C;
    else if (bus.i_quarter) coin_val = QUARTER_C;

    // One extra bit so a quarter on top of PRICE-1 cannot wrap.
    total = {1'b0, bus.i_sum} + coin_val;
    over  = total - PRICE_C;

    state_d  = state_q;
    change_d = change_q;
    sum_ld   = 1'b0;
    sum_next = bus.i_sum;
    // Hold the register in clear for as long as we are in reset.
    sum_rst  = i_rst;

    case (state_q)
      COLLECT: begin
        if (bus.i_cancel && (bus.i_sum != '0)) begin
          change_d = bus.i_sum;
          sum_rst  = 1'b0;
          state_d  = REFUND;
        end else if (coin_ok) begin
          if (total < PRICE_C) begin
            sum_ld   = 1'b1;
            sum_next = total[SUM_W-1:0];
          end else begin
            sum_rst  = 1'b0;
            change_d = over[SUM_W-1:0];
            state_d  = VEND;
          end
        end
      end
      VEND, REFUND: begin
        if (bus.i_vend_ack) begin
          change_d = '0;
          state_d  = COLLECT;
        end
      end
      default: begin
        change_d = '0;
        state_d  = COLLECT;
      end
    endcase

    vend_d     = (state_d == VEND);
    refund_d   = (state_d == REFUND);
    coin_rej_d = coin_any && !coin_ok;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= COLLECT;
      change_q   <= '0;
      vend_q     <= 1'b0;
      refund_q   <= 1'b0;
      coin_rej_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      change_q   <= change_d;
      vend_q     <= vend_d;
      refund_q   <= refund_d;
      coin_rej_q <= coin_rej_d;
    end
  end

  assign bus.o_sum_ld   = sum_ld;
  assign bus.o_sum_next = sum_next;
  assign bus.o_sum_rst  = sum_rst;
  assign bus.o_vend     = vend_q;
  assign bus.o_refund   = refund_q;
  assign bus.o_change   = change_q;
  assign bus.o_coin_rej = coin_rej_q;
  assign bus.o_busy     = (state_q != COLLECT);

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl. Includes a behavioural sum register (sync
// active-low clear, load strobe) wired back to i_sum, as in the real system.
module tb_vend_ctrl;
  localparam int SUM_W = 3;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  vend_ctrl_if #(.SUM_W(SUM_W)) bus ();

  vend_ctrl #(
    .SUM_W(SUM_W), .PRICE(4), .NICKEL_V(1), .DIME_V(2), .QUARTER_V(5)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  always #5 i_clk = ~i_clk;

  logic [SUM_W-1:0] sum_q;
  always_ff @(posedge i_clk) begin
    if (!bus.o_sum_rst)    sum_q <= '0;
    else if (bus.o_sum_ld) sum_q <= bus.o_sum_next;
  end
  assign bus.i_sum = sum_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic idle_in();
    bus.i_nickel = 1'b0; bus.i_dime = 1'b0; bus.i_quarter = 1'b0;
    bus.i_cancel = 1'b0; bus.i_vend_ack = 1'b0;
  endtask

  // Drive a coin for one cycle, checking the combinational load strobe first.
  task automatic coin(input logic n, input logic d, input logic q,
                      input logic exp_ld, input logic [SUM_W-1:0] exp_next,
                      input logic exp_rst, input string tag);
    bus.i_nickel = n; bus.i_dime = d; bus.i_quarter = q;
    #1;
    chk({tag, ".ld"},  32'(bus.o_sum_ld),  32'(exp_ld));
    if (exp_ld) chk({tag, ".next"}, 32'(bus.o_sum_next), 32'(exp_next));
    chk({tag, ".rst"}, 32'(bus.o_sum_rst), 32'(exp_rst));
    tick();
    idle_in();
  endtask

  task automatic ack();
    bus.i_vend_ack = 1'b1;
    tick();
    idle_in();
  endtask

  initial begin
    idle_in();
    // Reset: register cleared by clocks during reset, outputs low.
    tick(); tick();
    #1;
    chk("rst.sum_rst", 32'(bus.o_sum_rst), 32'd0);
    chk("rst.sum",     32'(sum_q),         32'd0);
    chk("rst.vend",    32'(bus.o_vend),    32'd0);
    chk("rst.refund",  32'(bus.o_refund),  32'd0);
    chk("rst.change",  32'(bus.o_change),  32'd0);
    chk("rst.rej",     32'(bus.o_coin_rej),32'd0);
    chk("rst.busy",    32'(bus.o_busy),    32'd0);
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    chk("rel.sum_rst", 32'(bus.o_sum_rst), 32'd1);
    @(negedge i_clk);

    // Four nickels: 1,2,3 loaded, 4th hits price with zero change.
    coin(1, 0, 0, 1, 3'd1, 1, "n1");
    coin(1, 0, 0, 1, 3'd2, 1, "n2");
    coin(1, 0, 0, 1, 3'd3, 1, "n3");
    chk("n3.sum", 32'(sum_q), 32'd3);
    coin(1, 0, 0, 0, 3'd0, 0, "n4");
    chk("n4.vend",   32'(bus.o_vend),   32'd1);
    chk("n4.change", 32'(bus.o_change), 32'd0);
    chk("n4.busy",   32'(bus.o_busy),   32'd1);
    chk("n4.sum",    32'(sum_q),        32'd0);
    ack();
    chk("ack1.vend", 32'(bus.o_vend), 32'd0);
    chk("ack1.busy", 32'(bus.o_busy), 32'd0);

    // Sum 3 plus quarter: total 8, change 4, register cleared.
    coin(0, 1, 0, 1, 3'd2, 1, "d1");
    coin(1, 0, 0, 1, 3'd3, 1, "n5");
    coin(0, 0, 1, 0, 3'd0, 0, "q1");
    chk("q1.vend",   32'(bus.o_vend),   32'd1);
    chk("q1.change", 32'(bus.o_change), 32'd4);
    chk("q1.sum",    32'(sum_q),        32'd0);
    ack();
    chk("ack2.vend",   32'(bus.o_vend),   32'd0);
    chk("ack2.change", 32'(bus.o_change), 32'd0);

    // Sum 2, nickel+dime together: rejected, sum unchanged.
    coin(0, 1, 0, 1, 3'd2, 1, "d2");
    coin(1, 1, 0, 0, 3'd0, 1, "nd");
    chk("nd.rej", 32'(bus.o_coin_rej), 32'd1);
    chk("nd.sum", 32'(sum_q),           32'd2);
    tick();
    chk("nd.rej_drop", 32'(bus.o_coin_rej), 32'd0);

    // Sum 3, cancel: refund of 3, register cleared.
    coin(1, 0, 0, 1, 3'd3, 1, "n6");
    bus.i_cancel = 1'b1;
    #1;
    chk("c1.rst", 32'(bus.o_sum_rst), 32'd0);
    tick(); idle_in();
    chk("c1.refund", 32'(bus.o_refund), 32'd1);
    chk("c1.vend",   32'(bus.o_vend),   32'd0);
    chk("c1.change", 32'(bus.o_change), 32'd3);
    chk("c1.sum",    32'(sum_q),        32'd0);
    ack();
    chk("ack3.refund", 32'(bus.o_refund), 32'd0);

    // Cancel at sum 0: ignored.
    bus.i_cancel = 1'b1;
    #1;
    chk("c0.rst", 32'(bus.o_sum_rst), 32'd1);
    tick(); idle_in();
    chk("c0.busy",   32'(bus.o_busy),   32'd0);
    chk("c0.refund", 32'(bus.o_refund), 32'd0);

    // Sum 1, cancel + nickel: cancel wins, coin rejected.
    coin(1, 0, 0, 1, 3'd1, 1, "n7");
    bus.i_cancel = 1'b1; bus.i_nickel = 1'b1;
    #1;
    chk("cn.ld",  32'(bus.o_sum_ld),  32'd0);
    chk("cn.rst", 32'(bus.o_sum_rst), 32'd0);
    tick(); idle_in();
    chk("cn.refund", 32'(bus.o_refund),   32'd1);
    chk("cn.change", 32'(bus.o_change),   32'd1);
    chk("cn.rej",    32'(bus.o_coin_rej), 32'd1);
    ack();

    // VEND with ack held low, then a dime: vend held, coin rejected.
    coin(0, 1, 0, 1, 3'd2, 1, "d3");
    coin(0, 1, 0, 0, 3'd0, 0, "d4");
    for (int i = 0; i < 10; i++) tick();
    chk("hold.vend", 32'(bus.o_vend), 32'd1);
    coin(0, 1, 0, 0, 3'd0, 1, "dv");
    chk("dv.vend", 32'(bus.o_vend),     32'd1);
    chk("dv.rej",  32'(bus.o_coin_rej), 32'd1);
    chk("dv.sum",  32'(sum_q),          32'd0);

    // Async reset mid-VEND: outputs drop without a clock edge.
    #2;
    i_rst = 1'b0;
    #1;
    chk("ar.vend",   32'(bus.o_vend),   32'd0);
    chk("ar.change", 32'(bus.o_change), 32'd0);
    chk("ar.busy",   32'(bus.o_busy),   32'd0);
    @(negedge i_clk);
    tick();
    i_rst = 1'b1;
    @(negedge i_clk);
    coin(1, 0, 0, 1, 3'd1, 1, "n8");
    chk("n8.sum", 32'(sum_q), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
